// File: rtl/alu_issue_pkg.sv
// Shared opcode, output-select and state encodings for the ALU issue/retire stage.
// Opcode layout is {arith_sel[1:0], out_sel[1:0]}.
package alu_issue_pkg;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0100;
   localparam logic [3:0] OP_INC = 4'b1000;
   localparam logic [3:0] OP_DEC = 4'b1100;
   localparam logic [3:0] OP_AND = 4'b0001;
   localparam logic [3:0] OP_OR  = 4'b0101;
   localparam logic [3:0] OP_XOR = 4'b1001;
   localparam logic [3:0] OP_SHR = 4'b0010;

   localparam logic [1:0] SEL_ARITH = 2'b00;
   localparam logic [1:0] SEL_LOGIC = 2'b01;
   localparam logic [1:0] SEL_SHIFT = 2'b10;
   localparam logic [1:0] SEL_RSVD  = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   // Subtract and increment need cin=1; add and decrement (B=all ones) need cin=0.
   function automatic logic carry_in(input logic [1:0] arith_sel);
      return arith_sel[1] ^ arith_sel[0];
   endfunction

endpackage

// File: rtl/alu_issue_sequencer_if.sv
// Operation intake, ALU drive/return and result handshake bundle for the issue stage.
// slave = the sequencer itself; master = the surrounding environment (producer, ALU, consumer).
interface alu_issue_sequencer_if #(
   parameter int N       = 6,
   parameter int SHAMT_W = 3
);
   logic               in_valid;
   logic               in_ready;
   logic [3:0]         in_op;
   logic [N-1:0]       in_a;
   logic [N-1:0]       in_b;
   logic [SHAMT_W-1:0] in_shamt;

   logic [N-1:0]       alu_a;
   logic [N-1:0]       alu_b;
   logic [1:0]         alu_sel;
   logic [1:0]         alu_sel1;
   logic               alu_cin;
   logic               alu_shin;
   logic [N-1:0]       alu_result;
   logic               alu_carry;

   logic               out_valid;
   logic               out_ready;
   logic [N-1:0]       out_result;
   logic               out_carry;
   logic               out_zero;
   logic               out_illegal;

   modport slave (
      input  in_valid, in_op, in_a, in_b, in_shamt,
      output in_ready,
      output alu_a, alu_b, alu_sel, alu_sel1, alu_cin, alu_shin,
      input  alu_result, alu_carry,
      output out_valid, out_result, out_carry, out_zero, out_illegal,
      input  out_ready
   );

   modport master (
      output in_valid, in_op, in_a, in_b, in_shamt,
      input  in_ready,
      input  alu_a, alu_b, alu_sel, alu_sel1, alu_cin, alu_shin,
      output alu_result, alu_carry,
      input  out_valid, out_result, out_carry, out_zero, out_illegal,
      output out_ready
   );
endinterface

// File: rtl/alu_issue_sequencer.sv
// Issues one op to the external combinational ALU, iterates 1-bit shifts, registers result/flags.
// Latency: out_valid rises max(1,shamt) cycles after the accept edge.
// Backpressure: result held in DONE until out_ready; ALU_ISSUE_OVERLAP_EN lets DONE accept the next op.
module alu_issue_sequencer
   import alu_issue_pkg::*;
#(
   parameter int N       = 6,
   parameter int SHAMT_W = 3
) (
   input  logic clk,
   input  logic rst_n,
   alu_issue_sequencer_if.slave bus
);

   state_t             state;
   state_t             state_next;

   logic [3:0]         op_reg;
   logic [N-1:0]       a_reg;
   logic [N-1:0]       b_reg;
   logic [SHAMT_W-1:0] cnt;
   logic [N-1:0]       res_reg;
   logic               carry_reg;
   logic               zero_reg;
   logic               illegal_reg;

   logic               accept;
   logic               exec_last;
   logic [1:0]         sel;

   assign sel = op_reg[1:0];

   always_comb begin
      state_next  = state;
`ifdef ALU_ISSUE_OVERLAP_EN
      bus.in_ready = (state == IDLE) || ((state == DONE) && bus.out_ready);
`else
      bus.in_ready = (state == IDLE);
`endif
      accept    = bus.in_valid && bus.in_ready;
      // Only a shift with more than one step stays in EXEC.
      exec_last = (sel != SEL_SHIFT) || (cnt <= SHAMT_W'(1));
      case (state)
         IDLE: if (accept) state_next = EXEC;
         EXEC: if (exec_last) state_next = DONE;
         DONE: if (bus.out_ready) state_next = accept ? EXEC : IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_reg      <= '0;
         a_reg       <= '0;
         b_reg       <= '0;
         cnt         <= '0;
         res_reg     <= '0;
         carry_reg   <= 1'b0;
         zero_reg    <= 1'b0;
         illegal_reg <= 1'b0;
      end else if (accept) begin
         op_reg      <= bus.in_op;
         a_reg       <= bus.in_a;
         b_reg       <= bus.in_b;
         cnt         <= bus.in_shamt;
         illegal_reg <= 1'b0;
      end else if (state == EXEC) begin
         case (sel)
            SEL_RSVD: begin
               res_reg     <= '0;
               carry_reg   <= 1'b0;
               zero_reg    <= 1'b1;
               illegal_reg <= 1'b1;
            end
            SEL_SHIFT: begin
               if (cnt == '0) begin
                  res_reg   <= a_reg;
                  carry_reg <= 1'b0;
                  zero_reg  <= (a_reg == '0);
               end else begin
                  // a_reg feeds the ALU back each step; the last step also lands in the result.
                  a_reg <= bus.alu_result;
                  cnt   <= cnt - 1'b1;
                  if (cnt == SHAMT_W'(1)) begin
                     res_reg   <= bus.alu_result;
                     carry_reg <= 1'b0;
                     zero_reg  <= (bus.alu_result == '0);
                  end
               end
            end
            default: begin
               res_reg   <= bus.alu_result;
               carry_reg <= (sel == SEL_ARITH) ? bus.alu_carry : 1'b0;
               zero_reg  <= (bus.alu_result == '0);
            end
         endcase
      end
   end

   assign bus.alu_a       = a_reg;
   assign bus.alu_b       = b_reg;
   assign bus.alu_sel     = op_reg[3:2];
   assign bus.alu_sel1    = op_reg[1:0];
   assign bus.alu_cin     = carry_in(op_reg[3:2]);
   assign bus.alu_shin    = a_reg[N-1];

   assign bus.out_valid   = (state == DONE);
   assign bus.out_result  = res_reg;
   assign bus.out_carry   = carry_reg;
   assign bus.out_zero    = zero_reg;
   assign bus.out_illegal = illegal_reg;

endmodule

// File: doc/alu_issue_sequencer.md
Name: alu_issue_sequencer

Overview:
- Sequential issue/retire stage directly upstream and downstream of the combinational N-bit ALU (adder/logic/shift mux datapath).
- Accepts one operation (opcode, A, B, shift amount) per valid/ready handshake and drives the ALU select, carry-in and shift-in lines.
- Iterates the 1-bit arithmetic right shift for multi-bit shifts, then registers result, carry and flags behind a valid/ready output handshake.

Parameters:
- N, 6, operand/result width; matches the ALU NUM_BITS.
- SHAMT_W, 3, width of the shift-amount field; the maximum shift is 2^SHAMT_W-1.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  stage can accept an operation.
- in_op  in  4  {arith_sel[1:0], out_sel[1:0]}; 0000 add, 0100 sub, 1000 A+1, 1100 A-1, 0001 and, 0101 or, 1001 xor, 0010 shift right.
- in_a  in  N  operand A.
- in_b  in  N  operand B.
- in_shamt  in  SHAMT_W  shift count; used only when out_sel=10.
- alu_a  out  N  to ALU operand A.
- alu_b  out  N  to ALU operand B.
- alu_sel  out  2  to ALU arithmetic/logic select.
- alu_sel1  out  2  to ALU output-mux select.
- alu_cin  out  1  to ALU carry-in; equals alu_sel[1]^alu_sel[0].
- alu_shin  out  1  to ALU shift-in; equals alu_a[N-1] (arithmetic shift).
- alu_result  in  N  from ALU.
- alu_carry  in  1  from ALU.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_result  out  N  registered result.
- out_carry  out  1  registered carry; 0 for logic and shift ops.
- out_zero  out  1  out_result==0.
- out_illegal  out  1  out_sel==11 was issued.

Behaviour:
- FSM states: IDLE, EXEC, DONE. Reset puts the FSM in IDLE.
- Reset values: all outputs 0, except in_ready=1 because it is decoded from IDLE.
- rst_n is asynchronous. Asserting it mid-EXEC or in DONE aborts the operation, and the result is discarded.
- IDLE: in_ready=1. On in_valid&in_ready, latch op, a, b and shamt into the working registers, load cnt=shamt, then go to EXEC.
- ALU drive: alu_a, alu_b, alu_sel and alu_sel1 come from the working registers in every state. The ALU is combinational, so alu_result is sampled in the same cycle.
- EXEC, out_sel != 10 and != 11: at the edge, res<=alu_result. carry<=alu_carry when out_sel=00, else 0. Go to DONE. Exactly one EXEC cycle.
- EXEC, out_sel=11: res<=0, carry<=0, illegal<=1, go to DONE.
- EXEC, shift, cnt=0: res<=a_reg (pass-through), carry<=0, go to DONE.
- EXEC, shift, cnt>=1: a_reg<=alu_result, cnt<=cnt-1. When cnt==1, also res<=alu_result and go to DONE.
- Latency: out_valid rises max(1,shamt) cycles after the accept edge.
- DONE: out_valid=1. out_result, out_carry, out_zero and out_illegal are held stable until out_valid&out_ready, then the FSM returns to IDLE. in_ready=0 in DONE.
- Subtract carry convention: carry=1 means no borrow. A-1 uses B=all ones with cin=0, so carry=1 unless A=0.
- No wrap handling is needed: add/sub wrap modulo 2^N and the carry is reported.
- in_* is ignored outside IDLE; in_valid may stay high.

Optional Feature:
- Macro ALU_ISSUE_OVERLAP_EN.
- Defined: in_ready = IDLE | (DONE & out_ready). A new op is accepted in the same cycle the result retires, with DONE->EXEC directly, giving one op every 2 cycles for non-shift ops.
- Undefined: in_ready is asserted in IDLE only, giving a minimum 3-cycle issue interval.

Decomposition:
- Package alu_issue_pkg holds:
  - opcode field constants (OP_ADD=4'b0000 ... OP_SHR=4'b0010);
  - out_sel encodings SEL_ARITH=00, SEL_LOGIC=01, SEL_SHIFT=10, SEL_RSVD=11;
  - the state enum.
- No sub-module is warranted: the FSM, counter and registers are one unit, and the ALU is instantiated by the parent.

Test Plan:
- Add, N=6: A=010000, B=001000, op 0000 -> after 1 cycle out_result=011000, carry=0, zero=0.
- Sub and decrement: op 0100 on the same operands -> 001000, carry=1. Op 1100 with A=000000 -> 111111, carry=0.
- Shift: A=110000, op 0010, shamt=2 -> out_valid 2 cycles after accept, result 111100, carry=0. With A=010000 and shamt=3 -> 000010. With shamt=0 -> 010000 after 1 cycle.
- Backpressure: hold out_ready=0 for 5 cycles -> outputs stable and in_ready=0. Then out_ready=1 -> retire; under ALU_ISSUE_OVERLAP_EN a pending op is accepted in that same cycle.
- Illegal and logic ops: op 0011 -> result 000000, out_illegal=1. Xor op 1001 with A=B -> zero=1, carry=0.
- Reset mid-shift: shamt=7, deassert rst_n at the 3rd EXEC cycle -> immediately out_valid=0, in_ready=1. After release, a new add completes correctly.
